regfile_wb_queue: RTL
=====================

// Module: regfile_wb_queue
// PURPOSE
//  Writer side of the BancodeRegistros write port (rd/datard/wren). Buffers writeback
//  requests from ALU/load paths in a DEPTH-entry FIFO, drains one per cycle into the
//  register bank, and offers youngest-match bypass of pending writes to rs1/rs2 readers.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >=2
//  XLEN   32  data width
//  AW     5   register index width
// PORTS
//  clk_i       in   1        clock; all state updates on rising edge
//  rst_ni      in   1        asynchronous reset, active-low
//  wb_valid_i  in   1        writeback request valid
//  wb_ready_o  out  1        queue can accept request
//  wb_rd_i     in   AW       destination register
//  wb_data_i   in   XLEN     writeback data
//  drain_en_i  in   1        permit write to bank this cycle
//  rd_o        out  AW       to bank rd_i
//  datard_o    out  XLEN     to bank datard_i
//  wren_o      out  1        to bank wren_i
//  rs1_i       in   AW       read index 1
//  rs1_hit_o   out  1        rs1 matches a pending entry
//  rs1_data_o  out  XLEN     bypass data for rs1
//  rs2_i       in   AW       read index 2
//  rs2_hit_o   out  1        rs2 matches a pending entry
//  rs2_data_o  out  XLEN     bypass data for rs2
//  count_o     out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst_ni low, async): rd/wr pointers and count clear; queued entries dropped,
//    never written. While low: wb_ready_o=0, wren_o=0, hit outputs 0, data outputs 0.
//  - Handshake: accept when wb_valid_i & wb_ready_o at edge. wb_ready_o = (count<DEPTH),
//    independent of pop in the same cycle (no full pass-through). valid may drop anytime.
//  - x0: accepted request with wb_rd_i==0 completes handshake but is discarded (no push).
//  - Drain: wren_o = drain_en_i & (count!=0); rd_o/datard_o = head entry (0 when empty).
//    Head popped at the edge where wren_o=1. Combinational path from drain_en_i only.
//  - Latency: entry accepted at edge N is earliest on write port in cycle N+1; no
//    fall-through when empty. Strict FIFO order, one write per cycle max.
//  - Simultaneous push+pop: count unchanged; legal when full only as pop (ready already 0).
//  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  - Bypass: search all valid entries including current head (bank updates only at edge,
//    so head is still pending). Youngest matching entry wins. rsX_i==0 -> hit 0, data 0.
//    No match -> hit 0, data 0. Purely combinational on rsX_i and queue state; an entry
//    accepted at edge N is visible to bypass from cycle N+1.
//  - Two pending writes to same rd: both drained in order; bypass returns the younger.
// STRUCTURE
//  - Package regfile_pkg: XLEN, REG_AW, wb_entry_t {rd, data} struct, REG_ZERO constant.
//  - One sub-module: wb_bypass_match (DEPTH entries + valid mask + head ptr + rs index ->
//    hit/data, youngest-priority); instantiated twice for rs1/rs2.
// TESTING
//  1 Reset mid-queue: push 3 entries, assert rst_ni low with drain_en_i=1 -> wren_o=0
//    immediately, count_o=0 after release, bank shows none of the 3 values.
//  2 Fill/drain: drain_en_i=0, push r1..r4=0x11..0x44 -> ready_o=0 at count 4; 5th held;
//    enable drain -> writes r1..r4 in order on 4 consecutive cycles, then 5th.
//  3 x0 discard: push rd=0 data=0xDEAD -> ready handshake completes, count_o stays 0,
//    wren_o never asserted, rs1_i=0 -> hit 0 data 0.
//  4 Bypass priority: push r5=0xAAAA then r5=0xBBBB, drain off -> rs1_i=5 hit 1 data
//    0xBBBB; drain one -> still 0xBBBB; drain second -> hit 0, bank r5=0xBBBB.
//  5 Full with simultaneous pop: count 4, drain_en_i=1, valid=1 -> that cycle no accept,
//    count 3 next cycle, accept following cycle -> count stays 3 under continuous traffic.
//  6 Wrap-around: 10 push/pop pairs with distinct rd -> bank contents match model,
//    bypass never returns stale entry after its pop edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank writeback path.
package regfile_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// Searches pending writeback entries for a read index; the youngest valid match wins.
module wb_bypass_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                  entries_i [DEPTH],
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [REG_AW-1:0]          rs_i,
    output logic                       hit_o,
    output logic [XLEN-1:0]            data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk slots oldest-to-youngest from the head; later matches overwrite earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if ((rs_i != REG_ZERO) && valid_i[idx] && (entries_i[idx].rd == rs_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register bank write port, with bypass of pending writes.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wb_valid_i,
    output logic                     wb_ready_o,
    input  logic [AW-1:0]            wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     drain_en_i,
    output logic [AW-1:0]            rd_o,
    output logic [XLEN-1:0]          datard_o,
    output logic                     wren_o,
    input  logic [AW-1:0]            rs1_i,
    output logic                     rs1_hit_o,
    output logic [XLEN-1:0]          rs1_data_o,
    input  logic [AW-1:0]            rs2_i,
    output logic                     rs2_hit_o,
    output logic [XLEN-1:0]          rs2_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [DEPTH-1:0] valid_mask;
    logic [PW-1:0]    age;

    // Ready is gated by reset so nothing is offered while the queue is held cleared.
    assign wb_ready_o = rst_ni && (count_q < FULL_CNT);
    assign wren_o     = drain_en_i && (count_q != '0);
    assign rd_o       = (count_q != '0) ? mem_q[rd_ptr_q].rd   : '0;
    assign datard_o   = (count_q != '0) ? mem_q[rd_ptr_q].data : '0;
    assign count_o    = count_q;

    // Writes to x0 finish the handshake but never occupy a slot.
    assign push = wb_valid_i && wb_ready_o && (wb_rd_i != REG_ZERO);
    assign pop  = wren_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // A slot is pending when its distance from the head is below the occupancy.
    always_comb begin
        valid_mask = '0;
        age        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age           = PW'(i) - rd_ptr_q;
            valid_mask[i] = ({1'b0, age} < count_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: wb_rd_i, data: wb_data_i};
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH)) u_rs1_match (
        .entries_i (mem_q),
        .valid_i   (valid_mask),
        .head_i    (rd_ptr_q),
        .rs_i      (rs1_i),
        .hit_o     (rs1_hit_o),
        .data_o    (rs1_data_o)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_rs2_match (
        .entries_i (mem_q),
        .valid_i   (valid_mask),
        .head_i    (rd_ptr_q),
        .rs_i      (rs2_i),
        .hit_o     (rs2_hit_o),
        .data_o    (rs2_data_o)
    );
endmodule
